mem_port_ctrl: RTL and testbench

Controller that sequences the single shared memory port driven by the 4-way request arbiter's master side. It turns the arbiter's level req/wr/addr/data handshake into a chip-select/ack bus cycle on an external memory, returns read data, and pulses rdy. A watchdog aborts hung accesses and raises a sticky error. It also enforces a one-cycle turnaround so the arbiter can re-grant between transactions.

---
 rtl/mem_port_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_port_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Shared memory port sequencer: turns the arbiter's level request into a
// chip-select/ack bus cycle, with a watchdog abort and a re-grant turnaround.
module mem_port_ctrl #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          rdy_o,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy_o,
  output logic          err_o,
  input  logic          err_clr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Timer value seen in the last ACCESS cycle before the watchdog fires.
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic          TMO_EN   = (TIMEOUT != 0);

  state_t          state_q, state_d;
  logic            cs_q, cs_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_hit;

  assign timeout_hit = TMO_EN && (timer_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    err_d   = err_q;
    timer_d = timer_q;

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = wr_i;
          cs_d    = 1'b1;
          timer_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          cs_d    = 1'b0;
          we_d    = 1'b0;
          rdy_d   = 1'b1;
          state_d = RESP;
        end else if (timeout_hit) begin
          // Abort: reads return all ones; the error flag beats a same-cycle clear.
          if (!we_q) begin
            rdata_d = '1;
          end
          err_d   = 1'b1;
          cs_d    = 1'b0;
          we_d    = 1'b0;
          rdy_d   = 1'b1;
          state_d = RESP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rdata_o   = rdata_q;
  assign rdy_o     = rdy_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: a per-cycle vector table for the basic
// bus cycles plus hand sequences for watchdog, reset and ack/timeout overlap.
module tb_mem_port_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] mrd;
  logic        ack;
  logic        err_clr;

  logic [63:0] a_rdata, a_addr, a_wdata;
  logic        a_rdy, a_cs, a_we, a_busy, a_err;
  logic [63:0] b_rdata, b_addr, b_wdata;
  logic        b_rdy, b_cs, b_we, b_busy, b_err;

  int checks;
  int failures;

  mem_port_ctrl #(.AW(64), .DW(64), .TIMEOUT(4), .TW(8)) u_dut_a (
    .clk(clk), .reset(reset), .req_i(req), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(a_rdata), .rdy_o(a_rdy), .mem_cs(a_cs),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_rdata(mrd), .mem_ack(ack), .busy_o(a_busy), .err_o(a_err),
    .err_clr_i(err_clr)
  );

  mem_port_ctrl #(.AW(64), .DW(64), .TIMEOUT(3), .TW(8)) u_dut_b (
    .clk(clk), .reset(reset), .req_i(req), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(b_rdata), .rdy_o(b_rdy), .mem_cs(b_cs),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_rdata(mrd), .mem_ack(ack), .busy_o(b_busy), .err_o(b_err),
    .err_clr_i(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        ack;
    logic [63:0] mrd;
    logic        cs;
    logic        we;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    logic        rdy;
    logic        busy;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic i_req, input logic i_wr, input logic [63:0] i_addr,
                         input logic [63:0] i_wdata, input logic i_ack, input logic [63:0] i_mrd,
                         input logic o_cs, input logic o_we, input logic [63:0] o_addr,
                         input logic [63:0] o_wdata, input logic o_rdy, input logic o_busy,
                         input logic [63:0] o_rdata);
    vec_t v;
    v.req = i_req; v.wr = i_wr; v.addr = i_addr; v.wdata = i_wdata;
    v.ack = i_ack; v.mrd = i_mrd;
    v.cs = o_cs; v.we = o_we; v.e_addr = o_addr; v.e_wdata = o_wdata;
    v.rdy = o_rdy; v.busy = o_busy; v.e_rdata = o_rdata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] W1 = 64'hDEADBEEF00000001;
  localparam logic [63:0] RD = 64'h0123456789ABCDEF;
  localparam logic [63:0] RA = 64'hAAAA000000000001;
  localparam logic [63:0] RB = 64'hBBBB000000000002;
  localparam logic [63:0] Z  = 64'h0;

  initial begin
    int cs_cnt;
    int rdy_cnt;
    logic done;
    checks   = 0;
    failures = 0;
    reset = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    mrd = '0; ack = 1'b0; err_clr = 1'b0;

    // write with wait states (ack in 3rd ACCESS cycle)
    add_vec(1, 1, 64'h10, W1, 0, Z,   1, 1, 64'h10, W1, 0, 1, Z);
    add_vec(1, 1, 64'h10, W1, 0, Z,   1, 1, 64'h10, W1, 0, 1, Z);
    add_vec(1, 1, 64'h10, W1, 0, Z,   1, 1, 64'h10, W1, 0, 1, Z);
    add_vec(1, 1, 64'h10, W1, 1, Z,   0, 0, Z,      Z,  1, 1, Z);
    add_vec(0, 0, Z,      Z,  0, Z,   0, 0, Z,      Z,  0, 1, Z);
    add_vec(0, 0, Z,      Z,  0, Z,   0, 0, Z,      Z,  0, 0, Z);
    // zero-wait read; ack outside ACCESS is ignored
    add_vec(1, 0, 64'h40, Z,  1, RD,  1, 0, 64'h40, Z,  0, 1, Z);
    add_vec(1, 0, 64'h40, Z,  1, RD,  0, 0, Z,      Z,  1, 1, RD);
    add_vec(0, 0, Z,      Z,  1, RD,  0, 0, Z,      Z,  0, 1, RD);
    add_vec(0, 0, Z,      Z,  1, RD,  0, 0, Z,      Z,  0, 0, RD);
    // back-to-back with req held high
    add_vec(1, 0, 64'h80, Z,  1, RA,  1, 0, 64'h80, Z,  0, 1, RD);
    add_vec(1, 0, 64'h80, Z,  1, RA,  0, 0, Z,      Z,  1, 1, RA);
    add_vec(1, 0, 64'h88, Z,  1, RB,  0, 0, Z,      Z,  0, 1, RA);
    add_vec(1, 0, 64'h88, Z,  1, RB,  0, 0, Z,      Z,  0, 0, RA);
    add_vec(1, 0, 64'h88, Z,  1, RB,  1, 0, 64'h88, Z,  0, 1, RA);
    add_vec(1, 0, 64'h88, Z,  1, RB,  0, 0, Z,      Z,  1, 1, RB);
    add_vec(0, 0, Z,      Z,  1, RB,  0, 0, Z,      Z,  0, 1, RB);
    add_vec(0, 0, Z,      Z,  0, Z,   0, 0, Z,      Z,  0, 0, RB);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", {63'd0, a_cs}, 64'd0);
    chk("rst_we", {63'd0, a_we}, 64'd0);
    chk("rst_rdy", {63'd0, a_rdy}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_err", {63'd0, a_err}, 64'd0);
    chk("rst_rdata", a_rdata, Z);
    chk("rst_addr", a_addr, Z);
    chk("rst_wdata", a_wdata, Z);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      req = vecs[i].req; wr = vecs[i].wr; addr = vecs[i].addr;
      wdata = vecs[i].wdata; ack = vecs[i].ack; mrd = vecs[i].mrd;
      tick();
      chk($sformatf("v%0d_cs", i), {63'd0, a_cs}, {63'd0, vecs[i].cs});
      chk($sformatf("v%0d_we", i), {63'd0, a_we}, {63'd0, vecs[i].we});
      chk($sformatf("v%0d_rdy", i), {63'd0, a_rdy}, {63'd0, vecs[i].rdy});
      chk($sformatf("v%0d_busy", i), {63'd0, a_busy}, {63'd0, vecs[i].busy});
      chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_err", i), {63'd0, a_err}, 64'd0);
      if (vecs[i].cs) begin
        chk($sformatf("v%0d_addr", i), a_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), a_wdata, vecs[i].e_wdata);
      end
      $display("vector %0d: cs=%0b we=%0b rdy=%0b busy=%0b rdata=%h",
               i, a_cs, a_we, a_rdy, a_busy, a_rdata);
    end

    // watchdog timeout on a read, TIMEOUT=4
    req = 1'b1; wr = 1'b0; addr = 64'h20; wdata = Z; ack = 1'b0; mrd = 64'h1234;
    cs_cnt = 0; rdy_cnt = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (a_cs) cs_cnt++;
      if (a_rdy) begin
        rdy_cnt++;
        done = 1'b1;
        chk("tmo_rdata", a_rdata, 64'hFFFFFFFFFFFFFFFF);
        chk("tmo_err_set", {63'd0, a_err}, 64'd1);
        req = 1'b0;
      end
    end
    chk("tmo_done", {63'd0, done}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (a_rdy) rdy_cnt++;
    end
    chk("tmo_cs_cycles", 64'(cs_cnt), 64'd4);
    chk("tmo_rdy_pulses", 64'(rdy_cnt), 64'd1);
    chk("tmo_err_sticky", {63'd0, a_err}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_err_clr", {63'd0, a_err}, 64'd0);
    $display("timeout seq: cs_cycles=%0d rdy_pulses=%0d err=%0b", cs_cnt, rdy_cnt, a_err);

    // asynchronous reset in the middle of an access
    req = 1'b1; wr = 1'b1; addr = 64'h50; wdata = 64'h55;
    tick();
    chk("rmid_cs_before", {63'd0, a_cs}, 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("rmid_cs", {63'd0, a_cs}, 64'd0);
    chk("rmid_rdy", {63'd0, a_rdy}, 64'd0);
    chk("rmid_busy", {63'd0, a_busy}, 64'd0);
    req = 1'b0;
    tick();
    reset = 1'b1;
    ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rlate%0d_rdy", c), {63'd0, a_rdy}, 64'd0);
      chk($sformatf("rlate%0d_busy", c), {63'd0, a_busy}, 64'd0);
      chk($sformatf("rlate%0d_cs", c), {63'd0, a_cs}, 64'd0);
    end
    ack = 1'b0;
    $display("reset seq: cs=%0b rdy=%0b busy=%0b", a_cs, a_rdy, a_busy);

    // ack coinciding with the timeout cycle, TIMEOUT=3
    req = 1'b1; wr = 1'b0; addr = 64'h30; mrd = 64'h5555AAAA5555AAAA; ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("coin%0d_cs", c), {63'd0, b_cs}, 64'd1);
      chk($sformatf("coin%0d_rdy", c), {63'd0, b_rdy}, 64'd0);
    end
    ack = 1'b1;
    tick();
    req = 1'b0;
    ack = 1'b0;
    chk("coin_rdy", {63'd0, b_rdy}, 64'd1);
    chk("coin_cs", {63'd0, b_cs}, 64'd0);
    chk("coin_rdata", b_rdata, 64'h5555AAAA5555AAAA);
    chk("coin_err", {63'd0, b_err}, 64'd0);
    repeat (3) tick();
    chk("coin_err_after", {63'd0, b_err}, 64'd0);
    $display("coincide seq: rdata=%h err=%0b", b_rdata, b_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
